// File: rtl/bounded_differentiator.sv
// Bounded differentiator: rebuilds the raw sample stream from a moving-window sum
// stream using x[n] = s[n] - s[n-1] + x[n-SIZE], with valid/ready on both sides.
module bounded_differentiator #(
    parameter int WIDTH        = 8,
    parameter int SIZE         = 6,
    parameter int LOG2_SIZE_P1 = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [WIDTH+LOG2_SIZE_P1-1:0] i_tdata,
    input  logic                          i_tvalid,
    output logic                          i_tready,
    output logic [WIDTH-1:0]              o_tdata,
    output logic                          o_tvalid,
    input  logic                          o_tready
);

    localparam int SW    = WIDTH + LOG2_SIZE_P1;
    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SIZE - 1);

    logic [SW-1:0]    prev_sum_q;
    logic [SW-1:0]    prev_sum_d;
    logic [WIDTH-1:0] hist_q [SIZE];
    logic [WIDTH-1:0] hist_d [SIZE];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [WIDTH-1:0] o_tdata_q;
    logic [WIDTH-1:0] o_tdata_d;
    logic             o_tvalid_q;
    logic             o_tvalid_d;

    logic             accept_s;
    logic [WIDTH-1:0] hist_rd_s;
    logic [SW-1:0]    diff_s;

    assign i_tready  = ~clear & (~o_tvalid_q | o_tready);
    assign accept_s  = i_tvalid & i_tready;
    assign hist_rd_s = hist_q[ptr_q];
    // Modulo-2^SW arithmetic; the oldest sample is sign-extended to the sum width.
    assign diff_s    = i_tdata - prev_sum_q + {{LOG2_SIZE_P1{hist_rd_s[WIDTH-1]}}, hist_rd_s};

    assign o_tdata   = o_tdata_q;
    assign o_tvalid  = o_tvalid_q;

    // Next-state logic: clear wipes history, accept advances the ring, drain drops valid.
    always_comb begin
        prev_sum_d = prev_sum_q;
        hist_d     = hist_q;
        ptr_d      = ptr_q;
        o_tdata_d  = o_tdata_q;
        o_tvalid_d = o_tvalid_q;
        if (clear) begin
            prev_sum_d = '0;
            for (int k = 0; k < SIZE; k++) begin
                hist_d[k] = '0;
            end
            ptr_d      = '0;
            o_tdata_d  = '0;
            o_tvalid_d = 1'b0;
        end else if (accept_s) begin
            prev_sum_d    = i_tdata;
            hist_d[ptr_q] = diff_s[WIDTH-1:0];
            o_tdata_d     = diff_s[WIDTH-1:0];
            o_tvalid_d    = 1'b1;
            if (ptr_q == PTR_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else if (o_tready) begin
            o_tvalid_d = 1'b0;
        end else begin
            o_tvalid_d = o_tvalid_q;
        end
    end

    // State registers with synchronous reset back to the integrator's post-reset state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sum_q <= '0;
            for (int k = 0; k < SIZE; k++) begin
                hist_q[k] <= '0;
            end
            ptr_q      <= '0;
            o_tdata_q  <= '0;
            o_tvalid_q <= 1'b0;
        end else begin
            prev_sum_q <= prev_sum_d;
            hist_q     <= hist_d;
            ptr_q      <= ptr_d;
            o_tdata_q  <= o_tdata_d;
            o_tvalid_q <= o_tvalid_d;
        end
    end

endmodule

// File: tb/tb_bounded_differentiator.sv
// Bench for bounded_differentiator: directed sum tables, corner-case sequences and
// random sample streams passed through a moving-window integrator model.
module tb_bounded_differentiator;

    localparam int WIDTH        = 8;
    localparam int SIZE         = 6;
    localparam int LOG2_SIZE_P1 = 3;
    localparam int SW           = WIDTH + LOG2_SIZE_P1;
    localparam int MASK         = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [SW-1:0]    i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready;

    int checks = 0;
    int errors = 0;
    int xs [301];

    typedef struct {
        int sum;
        int exp;
    } vec_t;
    vec_t tbl [$];

    bounded_differentiator #(
        .WIDTH(WIDTH), .SIZE(SIZE), .LOG2_SIZE_P1(LOG2_SIZE_P1)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tdata = '0; o_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One sum in, expected sample out one cycle later (o_tready held high).
    task automatic feed1(input string name, input int sum, input int exp);
        i_tdata = SW'(sum); i_tvalid = 1'b1; o_tready = 1'b1;
        #1;
        chk({name, "_ready"}, int'(i_tready), 1);
        @(posedge clk);
        @(negedge clk);
        i_tvalid = 1'b0;
        chk({name, "_valid"}, int'(o_tvalid), 1);
        chk({name, "_data"}, int'(o_tdata), exp & MASK);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) feed1(name, tbl[i].sum, tbl[i].exp);
        o_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_drain"}, int'(o_tvalid), 0);
    endtask

    // Feed xs[0..n-1] through a window-sum model; expect the same samples back in order.
    task automatic run_stream(input string name, input int n, input bit rnd_ready);
        int win [$];
        int exp_q [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int s;
        int held = 0;
        bit stalled = 1'b0;
        bit take;
        for (int k = 0; k < SIZE; k++) win.push_back(0);
        i_tvalid = 1'b0;
        while (got < n && cyc < 20 * n + 50) begin
            if (!i_tvalid && sent < n) begin
                void'(win.pop_front());
                win.push_back(xs[sent]);
                s = 0;
                foreach (win[k]) s += win[k];
                i_tdata  = SW'(s);
                i_tvalid = 1'b1;
                exp_q.push_back(xs[sent] & MASK);
                sent++;
            end
            o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                chk({name, "_stall_valid"}, int'(o_tvalid), 1);
                chk({name, "_stall_data"}, int'(o_tdata), held);
            end
            chk({name, "_ready"}, int'(i_tready), int'(!o_tvalid || o_tready));
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    chk({name, "_spurious_out"}, exp_q.size(), 1);
                end else begin
                    chk({name, "_data"}, int'(o_tdata), exp_q.pop_front());
                    got++;
                end
            end
            stalled = o_tvalid && !o_tready;
            held    = int'(o_tdata);
            take    = i_tvalid && i_tready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (take) i_tvalid = 1'b0;
        end
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        chk({name, "_count"}, got, n);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tdata = '0; o_tready = 1'b1;
        do_reset();
        #1;
        chk("reset_valid", int'(o_tvalid), 0);
        chk("reset_data", int'(o_tdata), 0);
        chk("reset_ready", int'(i_tready), 1);

        // Alternating 0x7F / 0x80 through a 6-sample window.
        tbl.delete();
        tbl.push_back('{127, 'h7F}); tbl.push_back('{-1, 'h80});
        tbl.push_back('{126, 'h7F}); tbl.push_back('{-2, 'h80});
        tbl.push_back('{125, 'h7F}); tbl.push_back('{-3, 'h80});
        tbl.push_back('{-3, 'h7F});  tbl.push_back('{-3, 'h80});
        tbl.push_back('{-3, 'h7F});  tbl.push_back('{-3, 'h80});
        @(negedge clk);
        run_table("alt");

        // Step to 0x7F, then a sum drop that decodes to -1.
        do_reset();
        tbl.delete();
        for (int k = 1; k <= 6; k++) tbl.push_back('{127 * k, 'h7F});
        tbl.push_back('{762, 'h7F}); tbl.push_back('{762, 'h7F});
        tbl.push_back('{634, 'hFF});
        run_table("step");

        // Ramp 0..300 truncated to signed 8 bits.
        do_reset();
        for (int k = 0; k <= 300; k++) xs[k] = ((k % 256) > 127) ? (k % 256) - 256 : (k % 256);
        run_stream("ramp", 301, 1'b0);

        // Random samples, full throughput then random backpressure.
        do_reset();
        for (int k = 0; k < 200; k++) xs[k] = int'($urandom_range(0, 255)) - 128;
        run_stream("rand_full", 200, 1'b0);
        do_reset();
        run_stream("rand_bp", 200, 1'b1);

        // Five stalled cycles holding a pending 0x7F, then release.
        do_reset();
        feed1("bp_first", 127, 'h7F);
        i_tdata = SW'(132); i_tvalid = 1'b1; o_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", int'(i_tready), 0);
            chk("bp_valid", int'(o_tvalid), 1);
            chk("bp_data", int'(o_tdata), 'h7F);
            @(posedge clk);
            @(negedge clk);
        end
        o_tready = 1'b1;
        #1;
        chk("bp_release_ready", int'(i_tready), 1);
        @(posedge clk);
        @(negedge clk);
        i_tvalid = 1'b0;
        chk("bp_next_valid", int'(o_tvalid), 1);
        chk("bp_next_data", int'(o_tdata), 5);

        // Clear mid-stream with an output pending and input offered.
        do_reset();
        run_stream("pre_clear", 10, 1'b0);
        i_tdata = SW'(300); i_tvalid = 1'b1; o_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1; i_tdata = SW'(55);
        #1;
        chk("clear_ready", int'(i_tready), 0);
        chk("clear_pending", int'(o_tvalid), 1);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; i_tvalid = 1'b0;
        chk("clear_valid", int'(o_tvalid), 0);
        feed1("post_clear0", 127, 'h7F);
        feed1("post_clear1", 77, 'hCE);

        // Reset with an undelivered output, then restart.
        i_tdata = SW'(127); i_tvalid = 1'b1; o_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_tvalid = 1'b0;
        chk("prerst_valid", int'(o_tvalid), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_valid", int'(o_tvalid), 0);
        chk("midrst_data", int'(o_tdata), 0);
        for (int k = 0; k < 50; k++) xs[k] = int'($urandom_range(0, 255)) - 128;
        run_stream("post_rst", 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
